// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage feeding the decoder. Generates sequential
//   word-aligned PCs, issues in-order requests to instruction memory, tags
//   each request with its PC and buffers returned words in a DEPTH-entry
//   prefetch FIFO. A redirect flushes the FIFO, drops every response that
//   belongs to the old path and restarts fetch at the new PC.
//
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   imem_req/imem_addr/imem_gnt  request channel (held until granted)
//   imem_rvalid/imem_rdata       in-order response channel
//   redirect_valid/redirect_pc   flush and restart (pc bits [1:0] ignored)
//   instr_valid/instr_ready      decode handshake for the FIFO head
//   instr/instr_pc/pc_plus8      head word, its address and address + 8
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] pc_plus8
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t        state_r;
    logic [31:0]   fetch_pc_r;
    logic [CW-1:0] outstanding_r;
    logic [CW-1:0] discard_r;
    logic [CW-1:0] count_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] tag_rd_r;
    logic [AW-1:0] tag_wr_r;
    logic [31:0]   fifo_instr_r [DEPTH];
    logic [31:0]   fifo_pc_r    [DEPTH];
    logic [31:0]   tag_pc_r     [DEPTH];
    logic          instr_valid_r;
    logic [31:0]   instr_r;
    logic [31:0]   instr_pc_r;
    logic [31:0]   pc_plus8_r;

    logic          grant_s;
    logic          resp_s;
    logic          keep_s;
    logic          pop_s;
    logic          credit_s;
    logic [31:0]   target_pc_s;
    logic [CW-1:0] out_next_s;
    logic [CW-1:0] discard_next_s;
    logic [CW-1:0] count_next_s;
    logic [AW-1:0] rd_next_s;
    logic [31:0]   head_instr_s;
    logic [31:0]   head_pc_s;

    assign imem_addr   = fetch_pc_r;
    assign instr_valid = instr_valid_r;
    assign instr       = instr_r;
    assign instr_pc    = instr_pc_r;
    assign pc_plus8    = pc_plus8_r;

    // Handshake decode, credit check and next-head selection
    always_comb begin
        target_pc_s = redirect_pc & 32'hFFFF_FFFC;
        // every granted or buffered word holds one FIFO slot, so the FIFO cannot overflow
        credit_s    = ({1'b0, outstanding_r} + {1'b0, count_r}) < DEPTH_W;
        imem_req    = (state_r == ST_FETCH) & ~redirect_valid & credit_s;
        grant_s     = imem_req & imem_gnt;
        // a response with nothing outstanding is a protocol error and is ignored
        resp_s      = imem_rvalid & (outstanding_r != {CW{1'b0}});
        keep_s      = resp_s & (state_r == ST_FETCH) & ~redirect_valid;
        // the head is wrong-path during a redirect, so it is not consumed
        pop_s       = instr_valid_r & instr_ready & ~redirect_valid;
        out_next_s     = outstanding_r + CW'(grant_s) - CW'(resp_s);
        discard_next_s = discard_r - CW'(resp_s & (state_r == ST_FLUSH));
        count_next_s   = count_r + CW'(keep_s) - CW'(pop_s);
        rd_next_s      = rd_ptr_r + AW'(pop_s);
        // a word landing in the slot that becomes the head is forwarded into the output register
        if (keep_s && (wr_ptr_r == rd_next_s)) begin
            head_instr_s = imem_rdata;
            head_pc_s    = tag_pc_r[tag_rd_r];
        end else begin
            head_instr_s = fifo_instr_r[rd_next_s];
            head_pc_s    = fifo_pc_r[rd_next_s];
        end
    end

    // Fetch FSM: fetch PC, outstanding requests and wrong-path discard count
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_IDLE;
            fetch_pc_r    <= RESET_PC;
            outstanding_r <= {CW{1'b0}};
            discard_r     <= {CW{1'b0}};
        end else begin
            outstanding_r <= out_next_s;
            case (state_r)
                ST_IDLE: begin
                    state_r   <= ST_FETCH;
                    discard_r <= {CW{1'b0}};
                    if (redirect_valid) begin
                        fetch_pc_r <= target_pc_s;
                    end
                end
                ST_FETCH: begin
                    if (redirect_valid) begin
                        fetch_pc_r <= target_pc_s;
                        discard_r  <= out_next_s;
                        if (out_next_s != {CW{1'b0}}) begin
                            state_r <= ST_FLUSH;
                        end else begin
                            state_r <= ST_FETCH;
                        end
                    end else if (grant_s) begin
                        fetch_pc_r <= fetch_pc_r + 32'd4;
                    end
                end
                ST_FLUSH: begin
                    discard_r <= discard_next_s;
                    if (redirect_valid) begin
                        fetch_pc_r <= target_pc_s;
                    end
                    if (discard_next_s == {CW{1'b0}}) begin
                        state_r <= ST_FETCH;
                    end else begin
                        state_r <= ST_FLUSH;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // FIFO and tag queue pointers, occupancy and registered decode outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_r       <= {CW{1'b0}};
            rd_ptr_r      <= {AW{1'b0}};
            wr_ptr_r      <= {AW{1'b0}};
            tag_rd_r      <= {AW{1'b0}};
            tag_wr_r      <= {AW{1'b0}};
            instr_valid_r <= 1'b0;
            instr_r       <= 32'h0;
            instr_pc_r    <= 32'h0;
            pc_plus8_r    <= 32'h8;
        end else if (redirect_valid) begin
            count_r       <= {CW{1'b0}};
            rd_ptr_r      <= {AW{1'b0}};
            wr_ptr_r      <= {AW{1'b0}};
            tag_rd_r      <= {AW{1'b0}};
            tag_wr_r      <= {AW{1'b0}};
            instr_valid_r <= 1'b0;
        end else begin
            count_r       <= count_next_s;
            instr_valid_r <= (count_next_s != {CW{1'b0}});
            rd_ptr_r      <= rd_next_s;
            if (keep_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
                tag_rd_r <= tag_rd_r + AW'(1'b1);
            end
            if (grant_s) begin
                tag_wr_r <= tag_wr_r + AW'(1'b1);
            end
            instr_r    <= head_instr_s;
            instr_pc_r <= head_pc_s;
            pc_plus8_r <= head_pc_s + 32'd8;
        end
    end

    // Prefetch FIFO words/PCs and the PC tag queue of issued requests
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_instr_r[i] <= 32'h0;
                fifo_pc_r[i]    <= 32'h0;
                tag_pc_r[i]     <= 32'h0;
            end
        end else begin
            if (keep_s) begin
                fifo_instr_r[wr_ptr_r] <= imem_rdata;
                fifo_pc_r[wr_ptr_r]    <= tag_pc_r[tag_rd_r];
            end
            if (grant_s) begin
                tag_pc_r[tag_wr_r] <= fetch_pc_r;
            end
        end
    end

    fetch_unit_checker #(.CW(CW)) u_checker (
        .clk         (clk),
        .reset_n     (reset_n),
        .imem_rvalid (imem_rvalid),
        .outstanding (outstanding_r)
    );

endmodule

// -----------------------------------------------------------------------------
// fetch_unit_checker
//   Protocol checks for fetch_unit: a memory response must always answer an
//   outstanding request.
// Ports: clk, reset_n, imem_rvalid, outstanding (current request count)
// -----------------------------------------------------------------------------
module fetch_unit_checker #(
    parameter int unsigned CW = 2
) (
    input logic          clk,
    input logic          reset_n,
    input logic          imem_rvalid,
    input logic [CW-1:0] outstanding
);
    rvalid_has_request: assert property (
        @(posedge clk) disable iff (!reset_n) imem_rvalid |-> (outstanding != {CW{1'b0}})
    );
endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] pc_plus8;

    int n_pass = 0;
    int n_total = 0;
    int cyc_n = 0;
    int gnt_pct = 100;
    int rdy_pct = 100;
    int lat_min = 1;
    int lat_max = 1;
    int pops_n = 0;

    logic [31:0] q_addr [$];
    int          q_due  [$];
    logic [31:0] m_fetch = 32'h0;
    logic [31:0] m_exp = 32'h0;
    logic        flush_pending = 1'b0;

    fetch_unit #(.DEPTH(2), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .pc_plus8       (pc_plus8)
    );

    always #5 clk = ~clk;

    // Memory contents: each word is a fixed function of its address
    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"}, 32'(imem_req), 32'h0);
        chk({tag, "_addr"}, imem_addr, 32'h0);
        chk({tag, "_valid"}, 32'(instr_valid), 32'h0);
        chk({tag, "_instr"}, instr, 32'h0);
        chk({tag, "_pc"}, instr_pc, 32'h0);
        chk({tag, "_pc8"}, pc_plus8, 32'h8);
    endtask

    // Hold reset three cycles with new knobs, release mid-cycle (cycle "c0", still idle)
    task automatic do_reset(input int gp, input int rp, input int lmin, input int lmax);
        reset_n = 1'b0;
        redirect_valid = 1'b0;
        gnt_pct = gp; rdy_pct = rp; lat_min = lmin; lat_max = lmax;
        tick(); tick(); tick();
        #1;
        chk_reset_outputs("reset");
        tick();
        reset_n = 1'b1;
    endtask

    // Memory + handshake driver: responses in order, at or after their due cycle
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc_n = cyc_n + 1;
            if (!reset_n) begin
                q_addr.delete();
                q_due.delete();
                imem_rvalid = 1'b0;
                imem_rdata = 32'h0;
            end else if (q_addr.size() > 0 && q_due[0] <= cyc_n) begin
                imem_rvalid = 1'b1;
                imem_rdata = word_of(q_addr[0]);
                void'(q_addr.pop_front());
                void'(q_due.pop_front());
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata = 32'h0;
            end
            imem_gnt = ($urandom_range(0, 99) < gnt_pct);
            instr_ready = ($urandom_range(0, 99) < rdy_pct);
        end
    end

    // Reference model: next fetch address and next decoded PC, checked every cycle
    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                chk_reset_outputs("in_reset");
                m_fetch = 32'h0;
                m_exp = 32'h0;
                flush_pending = 1'b0;
            end else begin
                if (flush_pending) chk("valid_after_redirect", 32'(instr_valid), 32'h0);
                flush_pending = 1'b0;
                if (redirect_valid) chk("req_during_redirect", 32'(imem_req), 32'h0);
                if (imem_req && imem_gnt) begin
                    chk("grant_addr", imem_addr, m_fetch);
                    q_addr.push_back(imem_addr);
                    q_due.push_back(cyc_n + $urandom_range(lat_min, lat_max));
                    m_fetch = m_fetch + 32'd4;
                end
                if (instr_valid) begin
                    chk("head_pc", instr_pc, m_exp);
                    chk("head_word", instr, word_of(instr_pc));
                    chk("head_pc8", pc_plus8, instr_pc + 32'd8);
                    if (instr_ready && !redirect_valid) begin
                        m_exp = m_exp + 32'd4;
                        pops_n++;
                    end
                end
                if (redirect_valid) begin
                    m_fetch = redirect_pc & 32'hFFFF_FFFC;
                    m_exp = m_fetch;
                    flush_pending = 1'b1;
                end
            end
        end
    end

    initial begin
        logic [31:0] g_q [$];
        logic [31:0] p_q [$];
        logic [31:0] p8_q [$];
        logic [31:0] w_q [$];
        int          grants;
        int          p0;
        int          settle;
        bit          found;

        // ---- 1: sequential fetch, 1-cycle memory, always ready
        do_reset(100, 100, 1, 1);
        #1;
        chk("t1_idle_req", 32'(imem_req), 32'h0);
        tick(); #1;
        chk("t1_first_req", 32'(imem_req), 32'h1);
        chk("t1_first_addr", imem_addr, 32'h0);
        p_q.delete(); p8_q.delete();
        for (int i = 0; i < 20; i++) begin
            if (instr_valid && instr_ready) begin p_q.push_back(instr_pc); p8_q.push_back(pc_plus8); end
            tick(); #1;
        end
        chk("t1_pops", 32'(p_q.size() >= 3), 32'h1);
        if (p_q.size() >= 3) begin
            chk("t1_pc0", p_q[0], 32'h0);  chk("t1_pc8_0", p8_q[0], 32'h8);
            chk("t1_pc1", p_q[1], 32'h4);  chk("t1_pc8_1", p8_q[1], 32'hC);
            chk("t1_pc2", p_q[2], 32'h8);  chk("t1_pc8_2", p8_q[2], 32'h10);
        end

        // ---- 2: decode stalled, DEPTH=2 limits fetch to two words
        do_reset(100, 0, 1, 1);
        grants = 0;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (imem_req && imem_gnt) grants++;
            tick();
        end
        #1;
        chk("t2_grants", 32'(grants), 32'd2);
        chk("t2_req_stopped", 32'(imem_req), 32'h0);
        chk("t2_valid", 32'(instr_valid), 32'h1);
        chk("t2_head_pc", instr_pc, 32'h0);
        chk("t2_head_word", instr, 32'hDEAD_BEEF);
        rdy_pct = 100;
        tick(); #1;
        chk("t2_pop0_pc", instr_pc, 32'h0);
        tick(); #1;
        chk("t2_pop1_pc", instr_pc, 32'h4);
        chk("t2_resume_req", 32'(imem_req), 32'h1);
        chk("t2_resume_addr", imem_addr, 32'h8);

        // ---- 3: redirect with PCs 8 and C in flight (3-cycle memory)
        do_reset(100, 100, 3, 3);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick(); #1;
            if (imem_req && imem_gnt && imem_addr == 32'hC) found = 1'b1;
        end
        chk("t3_reach_C", 32'(found), 32'h1);
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h103;
        #1;
        chk("t3_req_redirect", 32'(imem_req), 32'h0);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("t3_flush_req_a", 32'(imem_req), 32'h0);
        chk("t3_flush_valid", 32'(instr_valid), 32'h0);
        tick(); #1;
        chk("t3_flush_req_b", 32'(imem_req), 32'h0);
        g_q.delete(); p_q.delete(); w_q.delete();
        for (int i = 0; i < 20; i++) begin
            tick(); #1;
            if (imem_req && imem_gnt) g_q.push_back(imem_addr);
            if (instr_valid && instr_ready) begin p_q.push_back(instr_pc); w_q.push_back(instr); end
        end
        chk("t3_restart_seen", 32'(g_q.size() > 0 && p_q.size() > 0), 32'h1);
        if (g_q.size() > 0 && p_q.size() > 0) begin
            chk("t3_restart_addr", g_q[0], 32'h100);
            chk("t3_first_pc", p_q[0], 32'h100);
            chk("t3_first_word", w_q[0], 32'hDEAD_BFEF);
        end

        // ---- 4: redirect coinciding with a response and a decode pop
        do_reset(100, 100, 1, 1);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick(); #1;
            if (instr_valid) found = 1'b1;
        end
        chk("t4_head_seen", 32'(found), 32'h1);
        chk("t4_head_pc", instr_pc, 32'h0);
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        #1;
        chk("t4_req_redirect", 32'(imem_req), 32'h0);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("t4_valid_dropped", 32'(instr_valid), 32'h0);
        chk("t4_bubble_req", 32'(imem_req), 32'h1);
        chk("t4_bubble_addr", imem_addr, 32'h200);
        p_q.delete(); p8_q.delete(); w_q.delete();
        for (int i = 0; i < 10; i++) begin
            tick(); #1;
            if (instr_valid && instr_ready) begin p_q.push_back(instr_pc); p8_q.push_back(pc_plus8); w_q.push_back(instr); end
        end
        chk("t4_pops", 32'(p_q.size() > 0), 32'h1);
        if (p_q.size() > 0) begin
            chk("t4_first_pc", p_q[0], 32'h200);
            chk("t4_first_pc8", p8_q[0], 32'h208);
            chk("t4_first_word", w_q[0], 32'hDEAD_BCEF);
        end

        // ---- 5: address wrap at the top of memory
        do_reset(100, 100, 1, 1);
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("t5_target_addr", imem_addr, 32'hFFFF_FFFC);
        g_q.delete(); p_q.delete(); p8_q.delete();
        for (int i = 0; i < 12; i++) begin
            if (imem_req && imem_gnt) g_q.push_back(imem_addr);
            if (instr_valid && instr_ready) begin p_q.push_back(instr_pc); p8_q.push_back(pc_plus8); end
            tick(); #1;
        end
        chk("t5_counts", 32'(g_q.size() >= 2 && p_q.size() >= 2), 32'h1);
        if (g_q.size() >= 2 && p_q.size() >= 2) begin
            chk("t5_grant0", g_q[0], 32'hFFFF_FFFC);
            chk("t5_grant1", g_q[1], 32'h0);
            chk("t5_pc0", p_q[0], 32'hFFFF_FFFC);
            chk("t5_pc8_0", p8_q[0], 32'h4);
            chk("t5_pc1", p_q[1], 32'h0);
            chk("t5_pc8_1", p8_q[1], 32'h8);
        end

        // ---- 6: random grant/latency/ready with redirects and a mid-burst reset
        do_reset(70, 70, 1, 5);
        p0 = pops_n;
        settle = 0;
        for (int i = 0; i < 600; i++) begin
            if (i == 300) begin
                reset_n = 1'b0;
                redirect_valid = 1'b0;
                #1;
                chk_reset_outputs("midreset");
                tick(); tick();
                reset_n = 1'b1;
                settle = 0;
            end else begin
                settle++;
                if (settle > 4 && $urandom_range(0, 99) < 3) begin
                    redirect_valid = 1'b1;
                    case ($urandom_range(0, 2))
                        0: redirect_pc = $urandom();
                        1: redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                        default: redirect_pc = 32'h103;
                    endcase
                end else begin
                    redirect_valid = 1'b0;
                end
                tick();
            end
        end
        redirect_valid = 1'b0;
        tick(); tick();
        chk("t6_progress", 32'((pops_n - p0) >= 40), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
